// File: rtl/mem_align.sv
// Byte/half/word load-store aligner between a core port and a word memory.
// Define MEM_ALIGN_SPLIT_EN to split word-crossing accesses into two beats.
module mem_align #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req_val,
  output logic          core_req_rdy,
  input  logic [AW-1:0] core_req_addr,
  input  logic [DW-1:0] core_req_data,
  input  logic          core_req_fcn,
  input  logic [2:0]    core_req_typ,
  output logic          core_resp_val,
  output logic [DW-1:0] core_resp_data,
  output logic          core_misaligned,
  output logic          mem_req_val,
  input  logic          mem_req_rdy,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_data,
  output logic          mem_req_fcn,
  output logic [3:0]    mem_req_wmask,
  input  logic [DW-1:0] mem_resp_data
);

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  logic [1:0]    off;
  logic [3:0]    ones;
  logic [7:0]    mask8;
  logic          mis;
  logic          st;
  logic [AW-3:0] word;
  logic [DW-1:0] st_lo;
  logic [DW-1:0] ld_lo;

  assign off   = core_req_addr[1:0];
  assign st    = core_req_fcn;
  assign word  = core_req_addr[AW-1:2];
  assign mask8 = {4'b0000, ones} << off;
  assign st_lo = core_req_data << {off, 3'b000};
  assign ld_lo = mem_resp_data >> {off, 3'b000};

  // access size as a right-justified byte-lane mask
  always_comb begin
    ones = 4'b0000;
    case (core_req_typ[1:0])
      2'd1:    ones = 4'b0001;
      2'd2:    ones = 4'b0011;
      2'd3:    ones = 4'b1111;
      default: ones = 4'b0000;
    endcase
  end

  assign mis = (core_req_typ[1:0] == 2'd2 && off == 2'd3) ||
               (core_req_typ[1:0] == 2'd3 && off != 2'd0);

  function automatic logic [DW-1:0] ext(
    input logic [DW-1:0] v,
    input logic [2:0]    typ
  );
    logic [DW-1:0] r;
    case (typ)
      MT_B:    r = {{24{v[7]}}, v[7:0]};
      MT_BU:   r = {24'd0, v[7:0]};
      MT_H:    r = {{16{v[15]}}, v[15:0]};
      MT_HU:   r = {16'd0, v[15:0]};
      MT_W:    r = v;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef MEM_ALIGN_SPLIT_EN

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SPLIT = 2'b10
  } state_t;

  state_t        state;
  logic [23:0]   hold;
  logic [1:0]    nb;
  logic [AW-3:0] word_nx;
  logic [DW-1:0] st_hi;
  logic [DW-1:0] merged;

  assign nb      = 2'd0 - off;
  assign word_nx = word + {{(AW-3){1'b0}}, 1'b1};
  assign st_hi   = core_req_data >> {nb, 3'b000};
  assign merged  = {8'd0, hold} | (mem_resp_data << {nb, 3'b000});

  // beat control, lane steering and response merge
  always_comb begin
    core_req_rdy    = 1'b0;
    core_resp_val   = 1'b0;
    core_resp_data  = '0;
    core_misaligned = 1'b0;
    mem_req_val     = 1'b0;
    mem_req_addr    = {word, 2'b00};
    mem_req_data    = st ? st_lo : '0;
    mem_req_fcn     = core_req_fcn;
    mem_req_wmask   = st ? mask8[3:0] : 4'b0000;
    if (!rst && core_req_val) begin
      unique case (1'b1)
        state[0]: begin
          mem_req_val = 1'b1;
          if (!mis) begin
            core_req_rdy   = mem_req_rdy;
            core_resp_val  = mem_req_rdy;
            core_resp_data = st ? '0 : ext(ld_lo, core_req_typ);
          end
        end
        state[1]: begin
          mem_req_val    = 1'b1;
          mem_req_addr   = {word_nx, 2'b00};
          mem_req_data   = st ? st_hi : '0;
          mem_req_wmask  = st ? mask8[7:4] : 4'b0000;
          core_req_rdy   = mem_req_rdy;
          core_resp_val  = mem_req_rdy;
          core_resp_data = st ? '0 : ext(merged, core_req_typ);
        end
        default: begin
          mem_req_val = 1'b0;
        end
      endcase
    end
  end

  // state and first-beat read bytes advance only when memory accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      unique case (1'b1)
        state[0]: begin
          if (core_req_val && mis && mem_req_rdy) begin
            hold  <= ld_lo[23:0];
            state <= SPLIT;
          end
        end
        state[1]: begin
          if (mem_req_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  logic unused;
  assign unused = ^{clk, mask8[7:4]};

  // single-beat path; word-crossing requests trap immediately
  always_comb begin
    core_req_rdy    = 1'b0;
    core_resp_val   = 1'b0;
    core_resp_data  = '0;
    core_misaligned = 1'b0;
    mem_req_val     = 1'b0;
    mem_req_addr    = {word, 2'b00};
    mem_req_data    = st ? st_lo : '0;
    mem_req_fcn     = core_req_fcn;
    mem_req_wmask   = st ? mask8[3:0] : 4'b0000;
    if (!rst && core_req_val) begin
      if (mis) begin
        core_misaligned = 1'b1;
        core_req_rdy    = 1'b1;
        core_resp_val   = 1'b1;
      end else begin
        mem_req_val    = 1'b1;
        core_req_rdy   = mem_req_rdy;
        core_resp_val  = mem_req_rdy;
        core_resp_data = st ? '0 : ext(ld_lo, core_req_typ);
      end
    end
  end

`endif

endmodule

// File: tb/tb_mem_align.sv
// Bench for mem_align: directed vectors plus random requests
// checked against a byte-level memory model.
module tb_mem_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_val;
  logic        core_req_rdy;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_data;
  logic        core_req_fcn;
  logic [2:0]  core_req_typ;
  logic        core_resp_val;
  logic [31:0] core_resp_data;
  logic        core_misaligned;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_fcn;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_resp_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_align #(.AW(32), .DW(32)) dut (
    .clk(clk),
    .rst(rst),
    .core_req_val(core_req_val),
    .core_req_rdy(core_req_rdy),
    .core_req_addr(core_req_addr),
    .core_req_data(core_req_data),
    .core_req_fcn(core_req_fcn),
    .core_req_typ(core_req_typ),
    .core_resp_val(core_resp_val),
    .core_resp_data(core_resp_data),
    .core_misaligned(core_misaligned),
    .mem_req_val(mem_req_val),
    .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_fcn(mem_req_fcn),
    .mem_req_wmask(mem_req_wmask),
    .mem_resp_data(mem_resp_data)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = memword({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] lanemask(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [2:0] typ,
                       input logic fcn, input logic [31:0] data);
    core_req_val  = 1'b1;
    core_req_addr = a;
    core_req_typ  = typ;
    core_req_fcn  = fcn;
    core_req_data = data;
  endtask

  task automatic settle();
    #1;
    mem_resp_data = memword(mem_req_addr);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    core_req_val = 1'b0;
    mem_req_rdy  = 1'($urandom_range(0, 1));
    settle();
    chk("idle_mval", 32'(mem_req_val), 32'd0);
    chk("idle_rdy", 32'(core_req_rdy), 32'd0);
    chk("idle_resp", 32'(core_resp_val), 32'd0);
  endtask

  // One request from presentation to completion; pat gives mem
  // ready per cycle (LSB first, then held high).
  task automatic do_req(input logic [31:0] a, input logic [2:0] typ,
                        input logic fcn, input logic [31:0] data,
                        input logic [15:0] pat, output logic [31:0] got);
    int          size;
    int          nb;
    int          b;
    int          cyc;
    bit          done;
    logic [31:0] baddr [2];
    logic [3:0]  bmask [2];
    logic [31:0] bdata [2];
    logic [31:0] ba;
    logic [31:0] lv;
    size = (typ[1:0] == 2'd1) ? 1 : (typ[1:0] == 2'd2) ? 2 : 4;
    nb = 0;
    lv = '0;
    for (int k = 0; k < 2; k++) begin
      baddr[k] = '0;
      bmask[k] = '0;
      bdata[k] = '0;
    end
    for (int i = 0; i < size; i++) begin
      ba = a + 32'(i);
      if (nb == 0 || {ba[31:2], 2'b00} != baddr[nb-1]) begin
        baddr[nb] = {ba[31:2], 2'b00};
        nb++;
      end
      bmask[nb-1][ba[1:0]] = 1'b1;
      bdata[nb-1] = bdata[nb-1] |
        (((data >> (8*i)) & 32'hFF) << (8*ba[1:0]));
      lv = lv | (32'(byte_at(ba)) << (8*i));
    end
    if (size < 4 && !typ[2] && lv[8*size-1])
      lv = lv | (32'hFFFF_FFFF << (8*size));
    if (fcn) lv = '0;
    got = '0;
`ifndef MEM_ALIGN_SPLIT_EN
    if (nb > 1) begin
      @(negedge clk);
      drive(a, typ, fcn, data);
      mem_req_rdy = pat[0];
      settle();
      chk("trap_mis", 32'(core_misaligned), 32'd1);
      chk("trap_mval", 32'(mem_req_val), 32'd0);
      chk("trap_rdy", 32'(core_req_rdy), 32'd1);
      chk("trap_resp", 32'(core_resp_val), 32'd1);
      chk("trap_data", core_resp_data, 32'd0);
      got = core_resp_data;
    end else begin
`else
    begin
`endif
      b = 0;
      cyc = 0;
      done = 0;
      while (!done && cyc < 40) begin
        @(negedge clk);
        drive(a, typ, fcn, data);
        mem_req_rdy = (cyc < 16) ? pat[cyc] : 1'b1;
        settle();
        chk("mval", 32'(mem_req_val), 32'd1);
        chk("maddr", mem_req_addr, baddr[b]);
        chk("mfcn", 32'(mem_req_fcn), 32'(fcn));
        chk("wmask", 32'(mem_req_wmask), fcn ? 32'(bmask[b]) : 32'd0);
        if (fcn)
          chk("wdata", mem_req_data & lanemask(bmask[b]), bdata[b]);
        chk("mis0", 32'(core_misaligned), 32'd0);
        if (mem_req_rdy && b == nb - 1) begin
          chk("rdy_last", 32'(core_req_rdy), 32'd1);
          chk("resp_last", 32'(core_resp_val), 32'd1);
          chk("rdata", core_resp_data, lv);
          got = core_resp_data;
          done = 1;
        end else begin
          chk("rdy_wait", 32'(core_req_rdy), 32'd0);
          chk("resp_wait", 32'(core_resp_val), 32'd0);
          if (mem_req_rdy) b++;
        end
        cyc++;
      end
      if (!done) chk("timeout", 32'd0, 32'd1);
    end
  endtask

  logic [2:0]  tl [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
  logic [31:0] got;
  logic [31:0] ra;

  initial begin
    rst = 1'b1;
    core_req_val = 1'b0;
    core_req_addr = '0;
    core_req_data = '0;
    core_req_fcn = 1'b0;
    core_req_typ = 3'd3;
    mem_req_rdy = 1'b1;
    mem_resp_data = '0;

    // reset holds every handshake low even with a live request
    @(negedge clk);
    drive(32'h100, 3'd3, 1'b0, '0);
    settle();
    chk("rst_rdy", 32'(core_req_rdy), 32'd0);
    chk("rst_resp", 32'(core_resp_val), 32'd0);
    chk("rst_mis", 32'(core_misaligned), 32'd0);
    chk("rst_mval", 32'(mem_req_val), 32'd0);
    @(negedge clk);
    drive(32'h203, 3'd2, 1'b0, '0);
    settle();
    chk("rst_mis2", 32'(core_misaligned), 32'd0);
    chk("rst_resp2", 32'(core_resp_val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    mem[32'h100] = 32'h8765_4321;
    do_req(32'h100, 3'd3, 1'b0, '0, 16'hFFFF, got);
    chk("lw_100", got, 32'h8765_4321);

    mem[32'h100] = 32'h8000_0000;
    do_req(32'h103, 3'd1, 1'b0, '0, 16'hFFFF, got);
    chk("lb_103", got, 32'hFFFF_FF80);
    do_req(32'h103, 3'd5, 1'b0, '0, 16'hFFFF, got);
    chk("lbu_103", got, 32'h0000_0080);

    do_req(32'h102, 3'd2, 1'b1, 32'h0000_BEEF, 16'hFFFF, got);
    chk("sh_102_resp", got, 32'd0);
    idle_cycle();

`ifdef MEM_ALIGN_SPLIT_EN
    mem[32'h100] = 32'h4433_2211;
    mem[32'h104] = 32'h8877_6655;
    do_req(32'h101, 3'd3, 1'b0, '0, 16'hFFFF, got);
    chk("lw_101", got, 32'h5544_3322);
    do_req(32'hFFFF_FFFE, 3'd3, 1'b1, 32'hAABB_CCDD, 16'hFFFF, got);
    do_req(32'h101, 3'd3, 1'b0, '0, 16'h0011, got);
    chk("lw_101_stall", got, 32'h5544_3322);

    // reset while the second beat is pending
    @(negedge clk);
    drive(32'h101, 3'd3, 1'b0, '0);
    mem_req_rdy = 1'b1;
    settle();
    chk("sr_beat0", mem_req_addr, 32'h100);
    chk("sr_resp0", 32'(core_resp_val), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    settle();
    chk("sr_rst_resp", 32'(core_resp_val), 32'd0);
    chk("sr_rst_mval", 32'(mem_req_val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_req_rdy = 1'b0;
    settle();
    chk("sr_after_addr", mem_req_addr, 32'h100);
    chk("sr_after_resp", 32'(core_resp_val), 32'd0);
    do_req(32'h101, 3'd3, 1'b0, '0, 16'hFFFF, got);
    chk("sr_redo", got, 32'h5544_3322);
`else
    do_req(32'h203, 3'd2, 1'b0, '0, 16'hFFFF, got);
    chk("lh_203", got, 32'd0);
    idle_cycle();
    chk("lh_203_pulse", 32'(core_misaligned), 32'd0);
`endif

    mem.delete();
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0)
        ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        ra = 32'h100 + 32'($urandom_range(0, 63));
      do_req(ra, tl[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
             $urandom, 16'($urandom) | 16'hFF00, got);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_align.md
MEM_ALIGN -- requirements
Module: mem_align

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; only 32 is supported.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 core_req_val  in  1  core request valid.
REQ-006 core_req_rdy  out  1  request accepted this cycle; core holds all req fields stable while val=1 and rdy=0.
REQ-007 core_req_addr  in  AW  byte address.
REQ-008 core_req_data  in  DW  store data, right-justified.
REQ-009 core_req_fcn  in  1  M_XRD=0 load, M_XWR=1 store.
REQ-010 core_req_typ  in  3  MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6.
REQ-011 core_resp_val  out  1  load/store complete this cycle.
REQ-012 core_resp_data  out  DW  extended load data; 0 for stores.
REQ-013 core_misaligned  out  1  misaligned-access exception pulse.
REQ-014 mem_req_val  out  1  memory access valid.
REQ-015 mem_req_rdy  in  1  memory accepts the access this cycle.
REQ-016 mem_req_addr  out  AW  word-aligned address, bits [1:0]=0.
REQ-017 mem_req_data  out  DW  store data, lane-positioned.
REQ-018 mem_req_fcn  out  1  same encoding as core_req_fcn.
REQ-019 mem_req_wmask  out  4  byte-lane write enables; 0 on loads.
REQ-020 mem_resp_data  in  DW  asynchronous read data for mem_req_addr, valid in the same cycle.

Function
REQ-021 Misaligned: H/HU with addr[1:0]=3; W with addr[1:0]!=0; B/BU never.
REQ-022 States: IDLE, SPLIT; two-bit state register, one-hot-safe decode.
REQ-023 IDLE, aligned request: mem_req_val=1, mem_req_addr={addr[AW-1:2],2'b00}; core_req_rdy=core_resp_val=mem_req_rdy; zero-cycle latency.
REQ-024 Lane placement: store data shifted left by 8*addr[1:0]; wmask = typ-size ones shifted by addr[1:0], truncated to 4 bits.
REQ-025 Loads: bytes selected from lane addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-026 IDLE, misaligned, accepted by memory: first beat at word N carries lanes addr[1:0]..3; read bytes captured into a 24-bit hold register; core_req_rdy=0; next state SPLIT.
REQ-027 SPLIT: second beat at word N+1, modulo 2^AW (0xFFFF_FFFC wraps to 0x0000_0000), carries remaining low lanes; on mem_req_rdy, core_req_rdy=core_resp_val=1, merged data returned, next state IDLE.
REQ-028 mem_req_rdy=0 in any state: state and hold register unchanged, core_req_rdy=core_resp_val=0, mem_req_* held stable.
REQ-029 core_req_val=0 in IDLE: mem_req_val=0, no state change.
REQ-030 core_resp_val is never asserted for a request outside the cycle of its final beat; at most one response per accepted request.

Reset
REQ-031 rst=1 forces state to IDLE and the hold register to 0 at the next edge.
REQ-032 During and after reset: core_req_rdy=0, core_resp_val=0, core_misaligned=0, mem_req_val=0 while rst=1.
REQ-033 Reset in SPLIT abandons the access; a completed first store beat is not rolled back.

Configuration
REQ-034 Macro MEM_ALIGN_SPLIT_EN defined: misaligned accesses are split per REQ-026..027; core_misaligned is tied 0.
REQ-035 Macro undefined: SPLIT state and hold register are absent; a misaligned request gives mem_req_val=0, core_req_rdy=1, core_resp_val=1, core_resp_data=0, and core_misaligned=1 for that single cycle.

Verification
REQ-036 LW addr 0x100, mem word 0x8765_4321 -> same-cycle resp 0x8765_4321, mem addr 0x100.
REQ-037 LB addr 0x103, word 0x8000_0000 -> resp 0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-038 SH 0xBEEF at 0x102 -> mem data 0xBEEF_0000, wmask 0b1100, one beat.
REQ-039 SPLIT_EN: LW addr 0x101, words 0x100=0x4433_2211, 0x104=0x8877_6655 -> beats 0x100 then 0x104, resp 0x5544_3322 in cycle 2; SW 0xAABB_CCDD at 0xFFFF_FFFE -> wmask 0b1100 at 0xFFFF_FFFC, then 0b0011 at 0x0, wrapping.
REQ-040 mem_req_rdy low for 3 cycles in SPLIT -> outputs stable, no resp, then resp on the first ready cycle; rst pulse in SPLIT -> IDLE, no resp.
REQ-041 SPLIT_EN undefined: LH addr 0x203 -> core_misaligned=1 for one cycle, mem_req_val=0, resp 0.
